uart_tx_arbiter: RTL

- Shares one uart_tx transmitter between NREQ on-chip requesters using round-robin arbitration.
- Sequences the edge-triggered write handshake of uart_tx: data setup, wr strobe, then waits for the word to be accepted and the buffer to be empty again.
- Returns a one-cycle ack to the winning requester.
- Sits between register-file or DMA requesters and the uart_tx data/wr/buffempty pins.

---
 rtl/uart_tx_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NREQ requesters and sequencing its wr handshake.
// Optional wait-state watchdog with sticky err flag: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DW      = 9,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               txen,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    ack,
    output logic [2:0]         gnt_id,
    output logic               busy,
    output logic [DW-1:0]      tx_data,
    output logic               tx_wr,
    input  logic               tx_buffempty,
    output logic               err,
    input  logic               err_clr
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETUP     = 3'd1,
        STROBE    = 3'd2,
        RELEASE   = 3'd3,
        WAIT_ACC  = 3'd4,
        WAIT_DONE = 3'd5
    } state_t;

    state_t          state;
    state_t          state_next;

    logic            be_q;
    logic [IW-1:0]   rr;
    logic [IW-1:0]   gnt;
    logic [IW-1:0]   win;
    logic            win_vld;
    logic [DW-1:0]   win_data;
    logic            timeout_hit;
    logic            grant_c;
    logic            done_c;
    logic            timeout_c;
    logic [NREQ-1:0] ack_d;
    logic            tx_wr_d;
    logic            busy_d;

    // Round-robin pick: first asserted request scanning upward from rr+1.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (!win_vld && req[IW'((32'(rr) + k) % NREQ)]) begin
                win     = IW'((32'(rr) + k) % NREQ);
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win == IW'(i)) begin
                win_data = req_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Arbitration is held off while ack is high so the acked requester can withdraw first.
    always_comb begin
        state_next = state;
        if (!txen) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:      if (be_q && win_vld && ~|ack) state_next = SETUP;
                SETUP:     state_next = STROBE;
                STROBE:    state_next = RELEASE;
                RELEASE:   state_next = WAIT_ACC;
                WAIT_ACC: begin
                    if (!be_q) begin
                        state_next = WAIT_DONE;
                    end else if (timeout_hit) begin
                        state_next = IDLE;
                    end
                end
                WAIT_DONE: if (be_q || timeout_hit) state_next = IDLE;
                default:   state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        grant_c   = (state == IDLE) && (state_next == SETUP);
        done_c    = txen && (state == WAIT_DONE) && be_q;
        timeout_c = txen && timeout_hit &&
                    (((state == WAIT_ACC) && be_q) || ((state == WAIT_DONE) && !be_q));
        ack_d     = '0;
        if (done_c) begin
            ack_d[gnt] = 1'b1;
        end
        tx_wr_d   = (state_next == STROBE);
        busy_d    = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            be_q    <= 1'b0;
            rr      <= IW'(NREQ - 1);
            gnt     <= '0;
            tx_data <= '0;
            ack     <= '0;
            tx_wr   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            be_q  <= tx_buffempty;
            ack   <= ack_d;
            tx_wr <= tx_wr_d;
            busy  <= busy_d;
            if (grant_c) begin
                tx_data <= win_data;
                gnt     <= win;
            end
            if (done_c || timeout_c) begin
                rr <= gnt;
            end
        end
    end

    assign gnt_id = 3'(gnt);

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CW-1:0] wait_cnt;

    // Counts cycles spent in the current wait state; restarts on every state change.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state_next != state) begin
            wait_cnt <= '0;
        end else if ((state == WAIT_ACC) || (state == WAIT_DONE)) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    assign timeout_hit = ((state == WAIT_ACC) || (state == WAIT_DONE)) &&
                         (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (timeout_c) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg  = err_clr ^ (TIMEOUT == 0);
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

endmodule
